// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues one imem request at a time from the PC, loads IF/ID,
// and advances the PC once per accepted instruction; stalls buffer an early response, flushes drop work.
module fetch_stage #(
    parameter int                     ADDR_WIDTH  = 32,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  pc,
    output logic                   pc_write,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   stall,
    input  logic                   flush,
    output logic                   if_id_valid,
    output logic [INSTR_WIDTH-1:0] if_id_instr,
    output logic [ADDR_WIDTH-1:0]  if_id_pc,
    output logic [ADDR_WIDTH-1:0]  if_id_pc_plus1
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DROP
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_t                  r_state;
    logic                    r_imem_req;
    logic [ADDR_WIDTH-1:0]   r_imem_addr;
    logic [INSTR_WIDTH-1:0]  r_buffer;
    logic                    r_if_valid;
    logic [INSTR_WIDTH-1:0]  r_if_instr;
    logic [ADDR_WIDTH-1:0]   r_if_pc;
    logic [ADDR_WIDTH-1:0]   r_if_pc_plus1;

    state_t                  w_state_next;
    logic                    w_imem_req_next;
    logic [ADDR_WIDTH-1:0]   w_imem_addr_next;
    logic [INSTR_WIDTH-1:0]  w_buffer_next;
    logic                    w_load;
    logic [INSTR_WIDTH-1:0]  w_load_instr;
    logic                    w_if_valid_next;
    logic [INSTR_WIDTH-1:0]  w_if_instr_next;
    logic [ADDR_WIDTH-1:0]   w_if_pc_next;
    logic [ADDR_WIDTH-1:0]   w_if_pc_plus1_next;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        w_state_next     = r_state;
        w_imem_req_next  = r_imem_req;
        w_imem_addr_next = r_imem_addr;
        w_buffer_next    = r_buffer;
        w_load           = 1'b0;
        w_load_instr     = imem_rdata;

        unique case (r_state)
            S_IDLE: begin
                w_imem_req_next  = 1'b1;
                w_imem_addr_next = pc;
                w_state_next     = S_REQ;
            end
            S_REQ: begin
                if (imem_ack) begin
                    if (flush) begin
                        w_imem_req_next = 1'b0;
                        w_state_next    = S_IDLE;
                    end else if (!stall) begin
                        w_load           = 1'b1;
                        // pc+1 is the value the PC register takes at this same edge.
                        w_imem_addr_next = pc + ADDR_ONE;
                    end else begin
                        w_buffer_next   = imem_rdata;
                        w_imem_req_next = 1'b0;
                        w_state_next    = S_HOLD;
                    end
                end else if (flush) begin
                    w_state_next = S_DROP;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    w_state_next = S_IDLE;
                end else if (!stall) begin
                    w_load           = 1'b1;
                    w_load_instr     = r_buffer;
                    w_imem_req_next  = 1'b1;
                    w_imem_addr_next = pc + ADDR_ONE;
                    w_state_next     = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_ack) begin
                    w_imem_req_next = 1'b0;
                    w_state_next    = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        w_if_valid_next    = r_if_valid;
        w_if_instr_next    = r_if_instr;
        w_if_pc_next       = r_if_pc;
        w_if_pc_plus1_next = r_if_pc_plus1;
        if (w_load) begin
            w_if_valid_next    = 1'b1;
            w_if_instr_next    = w_load_instr;
            w_if_pc_next       = r_imem_addr;
            w_if_pc_plus1_next = r_imem_addr + ADDR_ONE;
        end else if (flush || !stall) begin
            // Flush kills and an un-stalled empty cycle bubbles; both keep the pc fields.
            w_if_valid_next = 1'b0;
            w_if_instr_next = NOP_INSTR;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_imem_req    <= 1'b0;
            r_imem_addr   <= '0;
            r_buffer      <= NOP_INSTR;
            r_if_valid    <= 1'b0;
            r_if_instr    <= NOP_INSTR;
            r_if_pc       <= '0;
            r_if_pc_plus1 <= '0;
        end else begin
            r_state       <= w_state_next;
            r_imem_req    <= w_imem_req_next;
            r_imem_addr   <= w_imem_addr_next;
            r_buffer      <= w_buffer_next;
            r_if_valid    <= w_if_valid_next;
            r_if_instr    <= w_if_instr_next;
            r_if_pc       <= w_if_pc_next;
            r_if_pc_plus1 <= w_if_pc_plus1_next;
        end
    end

    assign pc_write       = w_load;
    assign imem_req       = r_imem_req;
    assign imem_addr      = r_imem_addr;
    assign if_id_valid    = r_if_valid;
    assign if_id_instr    = r_if_instr;
    assign if_id_pc       = r_if_pc;
    assign if_id_pc_plus1 = r_if_pc_plus1;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: drives a PC register model and a simple instruction memory,
// one task per scenario, each comparing outputs against hand-computed values.
module tb_fetch_stage;

    logic        clock;
    logic        reset;
    logic [31:0] pc;
    logic        pc_write;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus1;

    int          total;
    int          bad;

    // Memory model: auto mode answers after 'lat' extra waiting cycles with 0x1000+addr.
    logic        auto_mem;
    int          lat;
    int          wait_cnt;
    logic        br_valid;
    logic [31:0] br_pc;

    fetch_stage #(
        .ADDR_WIDTH (32),
        .INSTR_WIDTH(32),
        .NOP_INSTR  (32'h0000_0000)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pc            (pc),
        .pc_write      (pc_write),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .flush         (flush),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_pc_plus1(if_id_pc_plus1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Called 1 time unit after a negedge; returns 1 time unit after the next negedge.
    // Updates the PC register and memory models from what was presented at the posedge in between.
    task automatic tick();
        logic p_req, p_ack, p_rst, p_pcw;
        #1;
        p_req = imem_req;
        p_ack = imem_ack;
        p_rst = reset;
        p_pcw = pc_write;
        @(negedge clock);
        if (p_rst) pc = 32'h0;
        else if (br_valid) begin
            pc       = br_pc;
            br_valid = 1'b0;
        end else if (p_pcw) pc = pc + 32'h1;
        if (p_rst || (p_req && p_ack)) wait_cnt = 0;
        else if (p_req) wait_cnt++;
        if (auto_mem) begin
            imem_ack   = imem_req && (wait_cnt >= lat);
            imem_rdata = 32'h1000 + imem_addr;
        end
        #1;
    endtask

    task automatic do_reset();
        auto_mem   = 1'b0;
        lat        = 0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        stall      = 1'b0;
        flush      = 1'b0;
        br_valid   = 1'b0;
        br_pc      = 32'h0;
        reset      = 1'b1;
        tick();
        tick();
        reset      = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({imem_req, imem_addr} !== {1'b0, 32'h0}) begin
            bad++;
            $display("FAIL reset_req got req=%b addr=%h exp req=0 addr=0", imem_req, imem_addr);
        end
        total++;
        if ({if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus1} !== {1'b0, 32'h0, 32'h0, 32'h0}) begin
            bad++;
            $display("FAIL reset_ifid got %b %h %h %h exp 0 00000000 00000000 00000000",
                     if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus1);
        end
        total++;
        if (pc_write !== 1'b0) begin
            bad++;
            $display("FAIL reset_pc_write got=%b exp=0", pc_write);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        auto_mem = 1'b1;
        lat      = 0;
        pc       = 32'h0;
        tick();
        total++;
        if ({imem_req, imem_addr, if_id_valid, pc_write} !== {1'b1, 32'h0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL b2b_first_req got req=%b addr=%h valid=%b pcw=%b exp 1 00000000 0 1",
                     imem_req, imem_addr, if_id_valid, pc_write);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if ({if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus1} !==
                {1'b1, 32'h1000 + 32'(i), 32'(i), 32'(i + 1)}) begin
                bad++;
                $display("FAIL b2b_ifid[%0d] got %b %h %h %h exp 1 %h %h %h", i, if_id_valid,
                         if_id_instr, if_id_pc, if_id_pc_plus1, 32'h1000 + 32'(i), 32'(i), 32'(i + 1));
            end
            total++;
            if ({imem_req, imem_addr, pc_write} !== {1'b1, 32'(i + 1), 1'b1}) begin
                bad++;
                $display("FAIL b2b_req[%0d] got req=%b addr=%h pcw=%b exp 1 %h 1", i, imem_req,
                         imem_addr, pc_write, 32'(i + 1));
            end
        end
        auto_mem = 1'b0;
        imem_ack = 1'b0;
    endtask

    task automatic test_latency();
        logic        exp_valid [7] = '{0, 0, 0, 1, 0, 0, 1};
        logic        exp_pcw   [7] = '{0, 0, 1, 0, 0, 1, 0};
        logic [31:0] exp_addr  [7] = '{0, 0, 0, 1, 1, 1, 2};
        logic [31:0] exp_instr [7] = '{0, 0, 0, 32'h1000, 0, 0, 32'h1001};
        int          pulses;
        int          loads;
        do_reset();
        auto_mem = 1'b1;
        lat      = 2;
        pc       = 32'h0;
        pulses   = 0;
        loads    = 0;
        for (int t = 0; t < 7; t++) begin
            tick();
            if (pc_write === 1'b1) pulses++;
            if (if_id_valid === 1'b1) loads++;
            total++;
            if ({imem_req, imem_addr, if_id_valid, if_id_instr, pc_write} !==
                {1'b1, exp_addr[t], exp_valid[t], exp_instr[t], exp_pcw[t]}) begin
                bad++;
                $display("FAIL lat_cycle[%0d] got req=%b addr=%h valid=%b instr=%h pcw=%b exp 1 %h %b %h %b",
                         t, imem_req, imem_addr, if_id_valid, if_id_instr, pc_write,
                         exp_addr[t], exp_valid[t], exp_instr[t], exp_pcw[t]);
            end
        end
        total++;
        if (pulses !== 2 || loads !== 2) begin
            bad++;
            $display("FAIL lat_pulse_count got pulses=%0d loads=%0d exp 2 2", pulses, loads);
        end
        auto_mem = 1'b0;
        imem_ack = 1'b0;
    endtask

    task automatic test_stall_hold();
        do_reset();
        pc = 32'h4;
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_1004;
        tick();
        imem_rdata = 32'hDEAD_BEEF;
        stall      = 1'b1;
        #1;
        total++;
        if (pc_write !== 1'b0) begin
            bad++;
            $display("FAIL stall_ack_pcw got=%b exp=0", pc_write);
        end
        tick();
        imem_ack = 1'b0;
        for (int t = 0; t < 3; t++) begin
            total++;
            if ({if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus1, imem_req, pc_write} !==
                {1'b1, 32'h1004, 32'h4, 32'h5, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL stall_hold[%0d] got %b %h %h %h req=%b pcw=%b exp 1 00001004 00000004 00000005 0 0",
                         t, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus1, imem_req, pc_write);
            end
            if (t < 2) tick();
        end
        stall = 1'b0;
        #1;
        total++;
        if (pc_write !== 1'b1) begin
            bad++;
            $display("FAIL stall_release_pcw got=%b exp=1", pc_write);
        end
        tick();
        total++;
        if ({if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus1} !== {1'b1, 32'hDEAD_BEEF, 32'h5, 32'h6}) begin
            bad++;
            $display("FAIL stall_release_ifid got %b %h %h %h exp 1 deadbeef 00000005 00000006",
                     if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus1);
        end
        total++;
        if ({imem_req, imem_addr, pc_write} !== {1'b1, 32'h6, 1'b0}) begin
            bad++;
            $display("FAIL stall_next_req got req=%b addr=%h pcw=%b exp 1 00000006 0", imem_req, imem_addr, pc_write);
        end
    endtask

    task automatic test_flush_inflight();
        do_reset();
        pc = 32'h7;
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0077;
        tick();
        imem_ack = 1'b0;
        flush    = 1'b1;
        br_valid = 1'b1;
        br_pc    = 32'h40;
        #1;
        total++;
        if (pc_write !== 1'b0) begin
            bad++;
            $display("FAIL flush_pcw got=%b exp=0", pc_write);
        end
        tick();
        flush = 1'b0;
        total++;
        if ({if_id_valid, if_id_instr, if_id_pc, imem_req, imem_addr} !== {1'b0, 32'h0, 32'h7, 1'b1, 32'h8}) begin
            bad++;
            $display("FAIL flush_kill got valid=%b instr=%h pc=%h req=%b addr=%h exp 0 00000000 00000007 1 00000008",
                     if_id_valid, if_id_instr, if_id_pc, imem_req, imem_addr);
        end
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0BAD;
        #1;
        total++;
        if ({pc_write, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h8}) begin
            bad++;
            $display("FAIL flush_drop_ack got pcw=%b req=%b addr=%h exp 0 1 00000008", pc_write, imem_req, imem_addr);
        end
        tick();
        imem_ack = 1'b0;
        total++;
        if ({imem_req, if_id_valid, if_id_instr} !== {1'b0, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL flush_discard got req=%b valid=%b instr=%h exp 0 0 00000000", imem_req, if_id_valid, if_id_instr);
        end
        tick();
        total++;
        if ({imem_req, imem_addr, if_id_valid} !== {1'b1, 32'h40, 1'b0}) begin
            bad++;
            $display("FAIL flush_redirect got req=%b addr=%h valid=%b exp 1 00000040 0", imem_req, imem_addr, if_id_valid);
        end
    endtask

    task automatic test_flush_stall_hold();
        do_reset();
        pc = 32'h1F;
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0011;
        tick();
        imem_rdata = 32'h0000_0055;
        stall      = 1'b1;
        tick();
        imem_ack = 1'b0;
        total++;
        if ({if_id_valid, if_id_instr, imem_req} !== {1'b1, 32'h11, 1'b0}) begin
            bad++;
            $display("FAIL fs_enter_hold got valid=%b instr=%h req=%b exp 1 00000011 0", if_id_valid, if_id_instr, imem_req);
        end
        flush    = 1'b1;
        br_valid = 1'b1;
        br_pc    = 32'h80;
        tick();
        flush = 1'b0;
        stall = 1'b0;
        total++;
        if ({if_id_valid, if_id_instr, if_id_pc, imem_req} !== {1'b0, 32'h0, 32'h1F, 1'b0}) begin
            bad++;
            $display("FAIL fs_flush got valid=%b instr=%h pc=%h req=%b exp 0 00000000 0000001f 0",
                     if_id_valid, if_id_instr, if_id_pc, imem_req);
        end
        tick();
        total++;
        if ({imem_req, imem_addr, if_id_valid} !== {1'b1, 32'h80, 1'b0}) begin
            bad++;
            $display("FAIL fs_new_req got req=%b addr=%h valid=%b exp 1 00000080 0", imem_req, imem_addr, if_id_valid);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0099;
        tick();
        imem_ack = 1'b0;
        total++;
        if ({if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus1} !== {1'b1, 32'h99, 32'h80, 32'h81}) begin
            bad++;
            $display("FAIL fs_after got %b %h %h %h exp 1 00000099 00000080 00000081",
                     if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus1);
        end
    endtask

    task automatic test_reset_mid_req();
        do_reset();
        pc = 32'h30;
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0033;
        tick();
        imem_ack = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if ({imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
            bad++;
            $display("FAIL mid_reset got req=%b addr=%h valid=%b instr=%h pc=%h exp 0 00000000 0 00000000 00000000",
                     imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        pc = 32'hFFFF_FFFF;
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_F0F0;
        tick();
        imem_ack = 1'b0;
        total++;
        if ({if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus1} !== {1'b1, 32'hF0F0, 32'hFFFF_FFFF, 32'h0}) begin
            bad++;
            $display("FAIL wrap_ifid got %b %h %h %h exp 1 0000f0f0 ffffffff 00000000",
                     if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus1);
        end
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            bad++;
            $display("FAIL wrap_next_addr got req=%b addr=%h exp 1 00000000", imem_req, imem_addr);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        wait_cnt   = 0;
        auto_mem   = 1'b0;
        lat        = 0;
        pc         = 32'h0;
        reset      = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        stall      = 1'b0;
        flush      = 1'b0;
        br_valid   = 1'b0;
        br_pc      = 32'h0;
        @(negedge clock);
        #1;
        test_reset();
        test_back_to_back();
        test_latency();
        test_stall_hold();
        test_flush_inflight();
        test_flush_stall_hold();
        test_reset_mid_req();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
